cc_loc_sequencer: RTL and testbench
===================================

Name: cc_loc_sequencer

Overview:
- Sequences one localization run.
- Resets and starts the three cross-correlation cores, then streams the shared sample-buffer address to them.
- Waits for the cores to finish, converts their lag indices to scaled tau values, and holds those on the localizer inputs.
- After a fixed settling time, captures the localizer position and presents it to the host with a valid/ack handshake.

Parameters:
- LENGTH, 8192, samples streamed per run.
- ADDR_W, 13, sample address width (log2 LENGTH).
- TAU_W, 32, signed tau output width.
- POS_W, 128, localizer position width.
- TAU_MUL, 44739, unsigned scale constant, round(2^(25+SHIFT)/49152000).
- SHIFT, 16, fractional bits of TAU_MUL.
- LOC_LAT, 4, cycles tau is held before the position is captured (1..255).
- TIMEOUT, 65536, WAIT_DONE watchdog limit in cycles (used only with CC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start_req  in  1  request a run; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- cc_rst  out  1  active-high reset to the cc cores.
- cc_start  out  1  one-cycle start pulse to the cc cores.
- samp_addr  out  ADDR_W  sample buffer address (combinational-read RAM feeding the cores).
- samp_en  out  1  high while samp_addr is valid stream data.
- cc_done  in  1  AND of the three core done flags.
- cc_index1, cc_index2, cc_index3  in  16 each  signed lag from each core.
- tau1, tau2, tau3  out  TAU_W each  signed scaled lags to the localizer; held between runs.
- loc_posx, loc_posy  in  POS_W each  localizer outputs (combinational from tau).
- res_posx, res_posy  out  POS_W each  captured position.
- res_valid  out  1  result available.
- res_ack  in  1  host consumes the result.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - cc_rst=1 while rst_n=0.
  - All other outputs 0: tau*, res_*, samp_addr, err_timeout.
- Reset mid-run aborts with no partial result.
- States:
  - IDLE: start_req=1 -> ARM. err_timeout is cleared on accept.
  - ARM: 1 cycle, cc_rst=1 -> START.
  - START: 1 cycle, cc_start=1, samp_addr=0 -> STREAM.
  - STREAM: LENGTH cycles, samp_en=1, samp_addr counts 0..LENGTH-1 (+1 per cycle). After LENGTH-1 -> WAIT_DONE, with samp_en=0 and samp_addr=0.
  - WAIT_DONE: cc_done=1 -> SCALE. Without CC_TIMEOUT_EN it waits indefinitely.
  - SCALE: 2 cycles.
    - Cycle 1 registers the three signed 16x17 products cc_indexN * TAU_MUL (34 bits).
    - Cycle 2 divides each product by 2^SHIFT, truncating toward zero (add 2^SHIFT-1 to negative products before the arithmetic shift), sign-extends to TAU_W, and loads tau1..3.
    - Then -> LOC_WAIT.
  - LOC_WAIT: LOC_LAT cycles. On the final cycle, res_posx/res_posy <= loc_posx/loc_posy and res_valid <= 1 -> HOLD.
  - HOLD: res_valid=1 until res_ack=1, then res_valid <= 0 -> IDLE.
- start_req outside IDLE is ignored, not queued.
- res_ack and start_req in the same HOLD cycle: the ack is processed and start is ignored. A new start_req is needed once back in IDLE.
- res_ack outside HOLD is ignored.
- tau* and res_pos* keep their last values until overwritten by the next run.
- cc_done asserting early (ARM/START/STREAM) is ignored; only WAIT_DONE samples it.
- Latency with an immediate cc_done: start_req accepted at edge 0 -> res_valid at edge LENGTH+LOC_LAT+5.

Optional Feature:
- Macro: CC_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - If cc_done is still 0 after TIMEOUT cycles, set err_timeout=1 and go to IDLE.
  - tau and res_* are unchanged and no res_valid is issued.
  - err_timeout stays set until the next accepted start_req or reset.
- Undefined: no counter; err_timeout is tied to 0.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles after a completed run -> busy=0, cc_rst=1, tau*=0, res_valid=0, samp_addr=0. Release -> cc_rst=0, IDLE.
2. Nominal run (LENGTH=16, LOC_LAT=4):
   - Stimulus: start_req pulse; cc_done=1 on entry to WAIT_DONE with indices 100, -100, 0; loc_posx=11*2^25, loc_posy=12*2^25.
   - Required:
     - cc_rst 1 cycle, then cc_start 1 cycle.
     - samp_en for exactly 16 cycles, samp_addr 0..15.
     - tau = 68, -68, 0.
     - res_valid at edge 25 with res_posx=369098752, res_posy=402653184.
3. Scaling extremes:
   - Index 32767 -> tau 22368.
   - Index -32768 -> tau -22369.
   - Index 1 -> 0.
   - Index -1 -> 0 (truncation toward zero).
4. Handshake:
   - res_valid holds 10 cycles with res_ack=0.
   - start_req during STREAM and HOLD is ignored.
   - res_ack+start_req in the same cycle -> IDLE, no new run.
   - A later start_req runs a normal sequence.
5. Timeout (CC_TIMEOUT_EN, TIMEOUT=64):
   - cc_done held 0 -> err_timeout=1 after 64 WAIT_DONE cycles, returns to IDLE, res_valid stays 0, previous tau is retained.
   - Next start_req clears err_timeout.
6. Mid-run reset: rst_n=0 at samp_addr=7 -> next edge IDLE with all outputs 0. A following start_req streams from addr 0 and completes normally.

Source files
------------

// File: rtl/cc_loc_sequencer.sv
// cc_loc_sequencer: sequences one localization run.
//   IDLE -> ARM (reset cores) -> START (start pulse) -> STREAM (LENGTH addresses)
//   -> WAIT_DONE -> SCALE1/SCALE2 (lag -> tau) -> LOC_WAIT (settle) -> HOLD (valid/ack).
// Optional feature: define CC_TIMEOUT_EN to enable the WAIT_DONE watchdog that
// raises the sticky err_timeout flag after TIMEOUT cycles without cc_done.
module cc_loc_sequencer #(
  parameter int unsigned LENGTH  = 8192,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned TAU_W   = 32,
  parameter int unsigned POS_W   = 128,
  parameter int unsigned TAU_MUL = 44739,
  parameter int unsigned SHIFT   = 16,
  parameter int unsigned LOC_LAT = 4,
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_req,
  output logic                    busy,
  output logic                    cc_rst,
  output logic                    cc_start,
  output logic [ADDR_W-1:0]       samp_addr,
  output logic                    samp_en,
  input  logic                    cc_done,
  input  logic signed [15:0]      cc_index1,
  input  logic signed [15:0]      cc_index2,
  input  logic signed [15:0]      cc_index3,
  output logic signed [TAU_W-1:0] tau1,
  output logic signed [TAU_W-1:0] tau2,
  output logic signed [TAU_W-1:0] tau3,
  input  logic [POS_W-1:0]        loc_posx,
  input  logic [POS_W-1:0]        loc_posy,
  output logic [POS_W-1:0]        res_posx,
  output logic [POS_W-1:0]        res_posy,
  output logic                    res_valid,
  input  logic                    res_ack,
  output logic                    err_timeout
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ARM    = 4'd1,
    S_START  = 4'd2,
    S_STREAM = 4'd3,
    S_WAIT   = 4'd4,
    S_SCALE1 = 4'd5,
    S_SCALE2 = 4'd6,
    S_LOC    = 4'd7,
    S_HOLD   = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(LENGTH - 1);
  localparam logic [7:0]         LAT_LAST  = 8'(LOC_LAT - 1);
  localparam logic signed [16:0] MUL_S     = 17'(TAU_MUL);
  // Bias added to negative products so the arithmetic shift truncates toward zero.
  localparam logic signed [33:0] RND       = 34'((64'd1 << SHIFT) - 64'd1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          lat_q;
  logic signed [33:0]  prod1_q, prod2_q, prod3_q;
  logic signed [TAU_W-1:0] tau1_q, tau2_q, tau3_q;
  logic [POS_W-1:0]    resx_q, resy_q;
  logic                res_valid_q;
  logic                timeout_hit_s;
  logic                arm_s;

  // Signed 16x17 multiply of a core lag by the unsigned scale constant.
  function automatic logic signed [33:0] mul_idx(input logic signed [15:0] idx);
    logic signed [33:0] a;
    logic signed [33:0] b;
    a = {{18{idx[15]}}, idx};
    b = {17'd0, MUL_S};
    return a * b;
  endfunction

  // Divide by 2^SHIFT truncating toward zero, then sign-extend to TAU_W.
  function automatic logic signed [TAU_W-1:0] div_tau(input logic signed [33:0] p);
    logic signed [33:0] adj;
    logic signed [33:0] q;
    if (p[33]) begin
      adj = p + RND;
    end else begin
      adj = p;
    end
    q = adj >>> SHIFT;
    return TAU_W'(q);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) state_d = S_ARM;
        else           state_d = S_IDLE;
      end
      S_ARM:   state_d = S_START;
      S_START: state_d = S_STREAM;
      S_STREAM: begin
        if (addr_q == ADDR_LAST) state_d = S_WAIT;
        else                     state_d = S_STREAM;
      end
      S_WAIT: begin
        if (cc_done)            state_d = S_SCALE1;
        else if (timeout_hit_s) state_d = S_IDLE;
        else                    state_d = S_WAIT;
      end
      S_SCALE1: state_d = S_SCALE2;
      S_SCALE2: state_d = S_LOC;
      S_LOC: begin
        if (lat_q == LAT_LAST) state_d = S_HOLD;
        else                   state_d = S_LOC;
      end
      S_HOLD: begin
        if (res_ack) state_d = S_IDLE;
        else         state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the current state.
  always_comb begin
    busy     = 1'b1;
    cc_start = 1'b0;
    samp_en  = 1'b0;
    arm_s    = 1'b0;
    case (state_q)
      S_IDLE:   busy     = 1'b0;
      S_ARM:    arm_s    = 1'b1;
      S_START:  cc_start = 1'b1;
      S_STREAM: samp_en  = 1'b1;
      default:  busy     = 1'b1;
    endcase
  end

  // Cores are held in reset during ARM and for as long as rst_n is low.
  assign cc_rst = arm_s | ~rst_n;

  // Sample address: counts through STREAM, zero everywhere else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (state_q == S_STREAM && state_d == S_STREAM) begin
      addr_q <= addr_q + ADDR_W'(1);
    end else begin
      addr_q <= '0;
    end
  end

  // Settling counter for LOC_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_q <= 8'd0;
    end else if (state_q == S_LOC && state_d == S_LOC) begin
      lat_q <= lat_q + 8'd1;
    end else begin
      lat_q <= 8'd0;
    end
  end

  // Scaling pipeline: products in SCALE1, tau load in SCALE2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod1_q <= '0;
      prod2_q <= '0;
      prod3_q <= '0;
      tau1_q  <= '0;
      tau2_q  <= '0;
      tau3_q  <= '0;
    end else if (state_q == S_SCALE1) begin
      prod1_q <= mul_idx(cc_index1);
      prod2_q <= mul_idx(cc_index2);
      prod3_q <= mul_idx(cc_index3);
    end else if (state_q == S_SCALE2) begin
      tau1_q <= div_tau(prod1_q);
      tau2_q <= div_tau(prod2_q);
      tau3_q <= div_tau(prod3_q);
    end else begin
      tau1_q <= tau1_q;
    end
  end

  // Result capture at the end of settling, released by the host ack in HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resx_q      <= '0;
      resy_q      <= '0;
      res_valid_q <= 1'b0;
    end else if (state_q == S_LOC && lat_q == LAT_LAST) begin
      resx_q      <= loc_posx;
      resy_q      <= loc_posy;
      res_valid_q <= 1'b1;
    end else if (state_q == S_HOLD && res_ack) begin
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= res_valid_q;
    end
  end

  assign samp_addr = addr_q;
  assign tau1      = tau1_q;
  assign tau2      = tau2_q;
  assign tau3      = tau3_q;
  assign res_posx  = resx_q;
  assign res_posy  = resy_q;
  assign res_valid = res_valid_q;

`ifdef CC_TIMEOUT_EN
  localparam int unsigned        TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // Watchdog counter: counts consecutive WAIT_DONE cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == S_WAIT && state_d == S_WAIT) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_hit_s = (state_q == S_WAIT) && !cc_done && (to_cnt_q == TO_LAST);

  // Sticky timeout flag, cleared when a new run is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start_req) begin
      err_q <= 1'b0;
    end else if (timeout_hit_s) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT != 32'd0);
  assign timeout_hit_s    = 1'b0;
  assign err_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_cc_loc_sequencer.sv
// Self-checking bench for cc_loc_sequencer (LENGTH=16, LOC_LAT=4, TIMEOUT=64).
module tb_cc_loc_sequencer;
  localparam int L   = 16;
  localparam int AW  = 4;
  localparam int LAT = 4;
  localparam int TO  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_req, busy, cc_rst, cc_start, samp_en, cc_done;
  logic [AW-1:0] samp_addr;
  logic signed [15:0] cc_index1, cc_index2, cc_index3;
  logic [31:0] tau1, tau2, tau3;
  logic [127:0] loc_posx, loc_posy, res_posx, res_posy;
  logic res_valid, res_ack, err_timeout;

  cc_loc_sequencer #(
    .LENGTH(L), .ADDR_W(AW), .TAU_W(32), .POS_W(128), .TAU_MUL(44739),
    .SHIFT(16), .LOC_LAT(LAT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req), .busy(busy),
    .cc_rst(cc_rst), .cc_start(cc_start), .samp_addr(samp_addr), .samp_en(samp_en),
    .cc_done(cc_done), .cc_index1(cc_index1), .cc_index2(cc_index2), .cc_index3(cc_index3),
    .tau1(tau1), .tau2(tau2), .tau3(tau3), .loc_posx(loc_posx), .loc_posy(loc_posy),
    .res_posx(res_posx), .res_posy(res_posy), .res_valid(res_valid), .res_ack(res_ack),
    .err_timeout(err_timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  // Reference scaling: integer division truncates toward zero.
  function automatic int scale(input int idx);
    longint p;
    p = longint'(idx) * 64'sd44739;
    return int'(p / 64'sd65536);
  endfunction

  // ---------------- behavioural model (timeline relative to accepted start) ----
  bit m_init = 1'b0, m_run = 1'b0, m_hold = 1'b0, m_err = 1'b0;
  int m_acc = 0, m_dn = -1;
  int m_idx[3];
  int m_tau[3];
  logic [127:0] m_px = '0, m_py = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_init = 1'b1; m_run = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_dn = -1;
      m_tau = '{0, 0, 0}; m_px = '0; m_py = '0;
    end else if (m_hold) begin
      if (res_ack) m_hold = 1'b0;
    end else if (!m_run) begin
      if (start_req) begin
        m_run = 1'b1; m_acc = cyc; m_dn = -1; m_err = 1'b0;
      end
    end else begin
      int d;
      d = cyc - m_acc;
      if (m_dn < 0) begin
        if (d >= L + 3) begin
          if (cc_done) m_dn = cyc;
`ifdef CC_TIMEOUT_EN
          else if (d == L + 2 + TO) begin m_run = 1'b0; m_err = 1'b1; end
`endif
        end
      end else begin
        if (cyc == m_dn + 1) begin
          m_idx[0] = cc_index1; m_idx[1] = cc_index2; m_idx[2] = cc_index3;
        end
        if (cyc == m_dn + 2) begin
          for (int k = 0; k < 3; k++) m_tau[k] = scale(m_idx[k]);
        end
        if (cyc == m_dn + 2 + LAT) begin
          m_px = loc_posx; m_py = loc_posy; m_run = 1'b0; m_hold = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------------
  always @(posedge clk) begin
    #2;
    if (m_init) begin
      int d;
      bit arm, stt, sen;
      logic [AW-1:0] ea;
      d   = cyc - m_acc;
      arm = m_run && (d == 0);
      stt = m_run && (d == 1);
      sen = m_run && (d >= 2) && (d <= L + 1);
      ea  = sen ? AW'(d - 2) : '0;
      chk("busy", 128'(busy), 128'(m_run || m_hold));
      chk("cc_rst", 128'(cc_rst), 128'(arm || !rst_n));
      chk("cc_start", 128'(cc_start), 128'(stt));
      chk("samp_en", 128'(samp_en), 128'(sen));
      chk("samp_addr", 128'(samp_addr), 128'(ea));
      chk32("tau1", tau1, m_tau[0]);
      chk32("tau2", tau2, m_tau[1]);
      chk32("tau3", tau3, m_tau[2]);
      chk("res_valid", 128'(res_valid), 128'(m_hold));
      chk("res_posx", res_posx, m_px);
      chk("res_posy", res_posy, m_py);
      chk("err_timeout", 128'(err_timeout), 128'(m_err));
    end
  end

  // ---------------- stimulus helpers ------------------------------------------
  task automatic set_idx(input int a, input int b, input int c);
    cc_index1 = 16'(a); cc_index2 = 16'(b); cc_index3 = 16'(c);
  endtask

  task automatic pulse_start(output int acc);
    @(negedge clk); start_req = 1'b1;
    @(negedge clk); start_req = 1'b0;
    acc = cyc;
  endtask

  task automatic run_to_valid(input int acc, output int lat, output int en_cnt);
    en_cnt = 0;
    lat    = -1;
    for (int k = 0; k < 300 && !res_valid; k++) begin
      if (samp_en) en_cnt++;
      @(negedge clk);
    end
    if (!res_valid) begin
      n_assert++; n_fail++;
      $display("FAIL res_valid_wait: got no res_valid expected res_valid within 300 cycles");
    end else begin
      lat = cyc - acc;
    end
  endtask

  task automatic ack_result();
    @(negedge clk); res_ack = 1'b1;
    @(negedge clk); res_ack = 1'b0;
  endtask

  // ---------------- directed sequence -----------------------------------------
  initial begin
    int acc, lat, en_cnt;
    rst_n = 1'b0; start_req = 1'b0; cc_done = 1'b0; res_ack = 1'b0;
    set_idx(0, 0, 0); loc_posx = '0; loc_posy = '0;
    repeat (2) @(negedge clk);
    chk("reset_cc_rst", 128'(cc_rst), 128'(1));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 128'(busy), 128'(0));
    chk("post_reset_cc_rst", 128'(cc_rst), 128'(0));

    // Nominal run; cc_done held high from the start (early done must be ignored).
    set_idx(100, -100, 0);
    loc_posx = 128'd11 << 25; loc_posy = 128'd12 << 25;
    cc_done = 1'b1;
    pulse_start(acc);
    run_to_valid(acc, lat, en_cnt);
    chk("nominal_latency", 128'(lat), 128'(25));
    chk("nominal_samp_en_cycles", 128'(en_cnt), 128'(16));
    chk32("nominal_tau1", tau1, 32'd68);
    chk32("nominal_tau2", tau2, -32'sd68);
    chk32("nominal_tau3", tau3, 32'd0);
    chk("nominal_posx", res_posx, 128'd369098752);
    chk("nominal_posy", res_posy, 128'd402653184);

    // Hold for 10 cycles without ack; a start_req in HOLD is ignored.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start_req = (k == 3);
    end
    start_req = 1'b0;
    chk("hold_valid_10", 128'(res_valid), 128'(1));
    // Ack and start in the same cycle: ack wins, no new run.
    @(negedge clk); res_ack = 1'b1; start_req = 1'b1;
    @(negedge clk); res_ack = 1'b0; start_req = 1'b0;
    chk("ack_clears_valid", 128'(res_valid), 128'(0));
    repeat (3) @(negedge clk);
    chk("ack_start_no_run", 128'(busy), 128'(0));

    // Scaling extremes; start_req during STREAM is ignored.
    set_idx(32767, -32768, 1);
    pulse_start(acc);
    repeat (5) @(negedge clk);
    start_req = 1'b1;
    @(negedge clk); start_req = 1'b0;
    run_to_valid(acc, lat, en_cnt);
    chk("extreme_latency", 128'(lat), 128'(25));
    chk32("tau_max", tau1, 32'd22368);
    chk32("tau_min", tau2, -32'sd22369);
    chk32("tau_plus1", tau3, 32'd0);
    ack_result();

    // Truncation toward zero; res_ack during STREAM is ignored; wide positions.
    set_idx(-1, 5, -5);
    loc_posx = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    loc_posy = {64'h8000000000000001, 64'h00000000FFFFFFFF};
    pulse_start(acc);
    repeat (4) @(negedge clk);
    res_ack = 1'b1;
    @(negedge clk); res_ack = 1'b0;
    run_to_valid(acc, lat, en_cnt);
    chk32("tau_minus1", tau1, 32'd0);
    chk32("tau_plus5", tau2, 32'd3);
    chk32("tau_minus5", tau3, -32'sd3);
    chk("wide_posx", res_posx, {64'h0123456789ABCDEF, 64'hFEDCBA9876543210});
    ack_result();

    // cc_done held low in WAIT_DONE.
    set_idx(7, 7, 7);
    cc_done = 1'b0;
    pulse_start(acc);
`ifdef CC_TIMEOUT_EN
    for (int k = 0; k < 200 && !err_timeout; k++) @(negedge clk);
    chk("timeout_flag", 128'(err_timeout), 128'(1));
    chk("timeout_cycles", 128'(cyc - acc), 128'(L + 2 + TO));
    chk("timeout_idle", 128'(busy), 128'(0));
    chk("timeout_no_valid", 128'(res_valid), 128'(0));
    chk32("timeout_tau_kept", tau2, 32'd3);
    cc_done = 1'b1;
    pulse_start(acc);
    chk("timeout_cleared", 128'(err_timeout), 128'(0));
    run_to_valid(acc, lat, en_cnt);
`else
    repeat (100) @(negedge clk);
    chk("wait_forever_busy", 128'(busy), 128'(1));
    chk("wait_forever_no_err", 128'(err_timeout), 128'(0));
    chk("wait_forever_no_valid", 128'(res_valid), 128'(0));
    cc_done = 1'b1;
    run_to_valid(acc, lat, en_cnt);
`endif
    chk32("late_done_tau", tau1, 32'd4);
    ack_result();

    // Mid-run reset at samp_addr 7.
    set_idx(200, -300, 400);
    loc_posx = 128'd77; loc_posy = 128'd88;
    pulse_start(acc);
    for (int k = 0; k < 50 && !(samp_en && samp_addr == 4'd7); k++) @(negedge clk);
    chk("midrun_addr7", 128'(samp_addr), 128'(7));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_busy", 128'(busy), 128'(0));
    chk("midrun_cc_rst", 128'(cc_rst), 128'(1));
    chk("midrun_addr", 128'(samp_addr), 128'(0));
    chk32("midrun_tau", tau1, 32'd0);
    chk("midrun_posx", res_posx, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(acc);
    run_to_valid(acc, lat, en_cnt);
    chk("rerun_latency", 128'(lat), 128'(25));
    chk("rerun_samp_en_cycles", 128'(en_cnt), 128'(16));
    chk32("rerun_tau1", tau1, 32'd136);
    chk32("rerun_tau2", tau2, -32'sd204);
    chk32("rerun_tau3", tau3, 32'd273);
    chk("rerun_posy", res_posy, 128'd88);

    // Reset for 2 cycles with a result still held.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cc_rst", 128'(cc_rst), 128'(1));
    chk32("rst_tau3", tau3, 32'd0);
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_addr", 128'(samp_addr), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_cc_rst", 128'(cc_rst), 128'(0));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
